uart_rx_buffered: RTL

//  Parametrised successor to the fixed 8-bit UART receiver. Adds configurable data width, 1/2 stop bits,
//  3-sample majority-vote bit decision, start-bit glitch rejection, and an RX FIFO with per-frame error flags.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_rx_buffered.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver.
//   rx_state_e   : receiver FSM states
//   PAR_EVEN/ODD : encodings of the PAR_TYP input
//   entry_width(): width of one RX FIFO entry, {stop_error, par_error, data}
//   majority3()  : 2-of-3 vote used for every bit decision
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Two flag bits ride along with each data word in the FIFO.
  localparam int FLAG_W = 2;

  function automatic int entry_width(input int data_w);
    return data_w + FLAG_W;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with drop-on-full.
//   clk, rst_n     : clock, async active-low reset (empties the FIFO)
//   push, din      : write request and data
//   pop            : advance head (ignored when empty)
//   dout           : head entry, valid whenever empty is 0
//   full, empty    : occupancy flags
//   count          : entries held
//   drop           : push refused because the FIFO was full and not popped
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full is still taken.
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
    count   = wr_ptr_q - rd_ptr_q;
    dout    = mem_q[rd_ptr_q[AW-1:0]];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Parametrised UART receiver with 3-sample majority voting, start-glitch
// rejection, optional parity, 1/2 stop bits and an RX FIFO of
// {stop_error, par_error, data} entries.
//   clk, rst                : clock, async active-low reset
//   RX_IN                   : async serial input, idle high
//   PAR_EN, PAR_TYP, STOP2  : frame format, latched at start detect
//   Prescale                : clocks per bit (values below 4 act as 4)
//   rd_en, clr_ovf          : pop head entry, clear sticky overflow
//   P_DATA, par_error,
//   stop_error, data_valid  : head-of-FIFO view, zero when empty
//   overflow                : sticky, a frame was dropped on a full FIFO
//   fifo_count, rx_busy     : occupancy, FSM not IDLE
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PRESCALE_W  = 6,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            RX_IN,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            STOP2,
  input  logic [PRESCALE_W-1:0]           Prescale,
  input  logic                            rd_en,
  input  logic                            clr_ovf,
  output logic [DATA_W-1:0]               P_DATA,
  output logic                            data_valid,
  output logic                            par_error,
  output logic                            stop_error,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            rx_busy
);

  localparam int ENTRY_W = entry_width(DATA_W);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s, rx_prev_q;
  rx_state_e              state_q, state_d;
  logic [PRESCALE_W-1:0]  cnt_q, cnt_d, p_q, p_d, mid;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   s0_q, s0_d, s1_q, s1_d, vote;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic                   par_err_q, par_err_d, stop_err_q, stop_err_d;
  logic                   push_q, push_d, ovf_q, ovf_d;
  logic                   at_m1, at_mid, at_p1, bit_end;
  logic                   fifo_empty, fifo_full, fifo_drop;
  logic [ENTRY_W-1:0]     fifo_dout;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], RX_IN};
  assign rx_s   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    bit_cnt_d  = bit_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    push_d     = 1'b0;

    mid     = p_q >> 1;
    at_m1   = (cnt_q == mid - PRESCALE_W'(1));
    at_mid  = (cnt_q == mid);
    at_p1   = (cnt_q == mid + PRESCALE_W'(1));
    bit_end = (cnt_q == p_q - PRESCALE_W'(1));
    vote    = majority3(s0_q, s1_q, rx_s);

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + PRESCALE_W'(1);
      if (at_m1)  s0_d = rx_s;
      if (at_mid) s1_d = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        // Falling edge only: a held-low line (break) cannot retrigger.
        if (rx_prev_q && !rx_s) begin
          state_d    = START;
          // The detect cycle is position 0 of the start bit.
          cnt_d      = PRESCALE_W'(1);
          p_d        = (Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          stop2_d    = STOP2;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      START: begin
        if (bit_end)        state_d = DATA;
        // Glitch check last so it wins when mid+1 is also the bit end.
        if (at_p1 && vote)  state_d = IDLE;
      end
      DATA: begin
        if (at_p1) shift_d = {vote, shift_q[DATA_W-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == 4'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (at_p1)   par_err_d = vote != (^shift_q ^ (par_typ_q == PAR_ODD));
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) bit_cnt_d = bit_cnt_q + 4'd1;
        if (at_p1) begin
          if (!vote) stop_err_d = 1'b1;
          // Leave early so a new start edge is caught in the rest of the stop bit.
          if (bit_cnt_q == {3'b000, stop2_q}) begin
            state_d = IDLE;
            push_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear.
    ovf_d = fifo_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      push_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      bit_cnt_q  <= bit_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      push_q     <= push_d;
      ovf_q      <= ovf_d;
    end
  end

  // Frame fields stay stable during the push cycle even if a new start is detected then.
  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_q),
    .din   ({stop_err_q, par_err_q, shift_q}),
    .pop   (rd_en),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign data_valid = !fifo_empty;
  assign P_DATA     = data_valid ? fifo_dout[DATA_W-1:0] : '0;
  assign par_error  = data_valid & fifo_dout[DATA_W];
  assign stop_error = data_valid & fifo_dout[DATA_W+1];
  assign overflow   = ovf_q;
  assign rx_busy    = (state_q != IDLE);

endmodule
